// File: rtl/icache_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icache_ctrl_pkg: shared widths, geometry defaults, FSM state encoding    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package icache_ctrl_pkg;
  localparam int ADDR_WID           = 32;
  localparam int INST_WID           = 32;
  localparam int ICACHE_OFFSET_BITS = 4;
  localparam int ICACHE_INDEX_BITS  = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_RESP   = 2'd2
  } state_e;
endpackage
`default_nettype wire

// File: rtl/icache_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icache_ctrl_if: request/response word bus (en/pc out, done/data back)    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface icache_ctrl_if;
  import icache_ctrl_pkg::*;

  logic                en;
  logic [ADDR_WID-1:0] pc;
  logic                done;
  logic [INST_WID-1:0] data;

  modport master (output en, output pc, input done, input data);
  modport slave  (input en, input pc, output done, output data);
endinterface
`default_nettype wire

// File: rtl/icache_ctrl_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icache_array: valid/tag/data storage, combinational read, sync write     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module icache_array
  import icache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int WORD_W     = ICACHE_OFFSET_BITS - 2,
  parameter int TAG_W      = ADDR_WID - ICACHE_OFFSET_BITS - ICACHE_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  input  logic [WORD_W-1:0]     rd_word_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [INST_WID-1:0]   rd_data_o,
  input  logic                  inv_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic                  data_we_i,
  input  logic [WORD_W-1:0]     wr_word_i,
  input  logic [INST_WID-1:0]   wr_data_i,
  input  logic                  tag_we_i,
  input  logic [TAG_W-1:0]      wr_tag_i
);
  localparam int LINES = 2 ** INDEX_BITS;
  localparam int WORDS = 2 ** WORD_W;

  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [INST_WID-1:0] data_q [LINES][WORDS];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][rd_word_i];

  // Invalidation targets the line being looked up; install targets the refill line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (inv_i)    valid_q[rd_idx_i] <= 1'b0;
      if (tag_we_i) valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we_i) data_q[wr_idx_i][wr_word_i] <= wr_data_i;
    if (tag_we_i)  tag_q[wr_idx_i]             <= wr_tag_i;
  end
endmodule
`default_nettype wire

// File: rtl/icache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icache_ctrl: direct-mapped icache + word-by-word refill sequencer        |
// | Rev 1.0 -- optional hit/miss counters under ICACHE_PERF_EN               |
// +--------------------------------------------------------------------------+
module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int OFFSET_BITS = ICACHE_OFFSET_BITS,
  parameter int INDEX_BITS  = ICACHE_INDEX_BITS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy_i,
  input  logic          rollback_i,
  icache_ctrl_if.slave  fetch_if,
  icache_ctrl_if.master mem_if
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]   perf_hit_o,
  output logic [31:0]   perf_miss_o
`endif
);
  localparam int WORD_W = (OFFSET_BITS > 2) ? OFFSET_BITS - 2 : 1;
  localparam int TAG_W  = ADDR_WID - OFFSET_BITS - INDEX_BITS;
  localparam logic [WORD_W-1:0]   LAST      = WORD_W'((64'd1 << (OFFSET_BITS - 2)) - 64'd1);
  localparam logic [ADDR_WID-1:0] LINE_MASK = ADDR_WID'((64'd1 << OFFSET_BITS) - 64'd1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   cnt_q, cnt_d;
  logic                mc_en_q, mc_en_d;
  logic [ADDR_WID-1:0] mc_pc_q, mc_pc_d;
  logic                if_done_q, if_done_d;
  logic [INST_WID-1:0] if_data_q, if_data_d;
  logic [ADDR_WID-1:0] pc_q, pc_d;
  logic [INST_WID-1:0] capt_q, capt_d;

  logic [INDEX_BITS-1:0] w_lk_idx, w_rf_idx;
  logic [TAG_W-1:0]      w_lk_tag, w_rf_tag, w_rd_tag;
  logic [WORD_W-1:0]     w_lk_word, w_rf_word;
  logic                  w_rd_valid, w_hit;
  logic [INST_WID-1:0]   w_rd_data;
  logic                  w_inv, w_data_we, w_tag_we;

  // Shifts rather than part-selects keep OFFSET_BITS=2 legal.
  assign w_lk_idx  = INDEX_BITS'(fetch_if.pc >> OFFSET_BITS);
  assign w_lk_tag  = TAG_W'(fetch_if.pc >> (OFFSET_BITS + INDEX_BITS));
  assign w_lk_word = WORD_W'(fetch_if.pc >> 2) & LAST;
  assign w_rf_idx  = INDEX_BITS'(pc_q >> OFFSET_BITS);
  assign w_rf_tag  = TAG_W'(pc_q >> (OFFSET_BITS + INDEX_BITS));
  assign w_rf_word = WORD_W'(pc_q >> 2) & LAST;
  assign w_hit     = w_rd_valid && (w_rd_tag == w_lk_tag);

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .WORD_W     (WORD_W),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (w_lk_idx),
    .rd_word_i  (w_lk_word),
    .rd_valid_o (w_rd_valid),
    .rd_tag_o   (w_rd_tag),
    .rd_data_o  (w_rd_data),
    .inv_i      (w_inv & rdy_i),
    .wr_idx_i   (w_rf_idx),
    .data_we_i  (w_data_we & rdy_i),
    .wr_word_i  (cnt_q),
    .wr_data_i  (mem_if.data),
    .tag_we_i   (w_tag_we & rdy_i),
    .wr_tag_i   (w_rf_tag)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mc_en_d   = mc_en_q;
    mc_pc_d   = mc_pc_q;
    if_done_d = 1'b0;
    if_data_d = if_data_q;
    pc_d      = pc_q;
    capt_d    = capt_q;
    w_inv     = 1'b0;
    w_data_we = 1'b0;
    w_tag_we  = 1'b0;
    if (rollback_i) begin
      state_d = ST_IDLE;
      mc_en_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch_if.en) begin
            if (w_hit) begin
              if_done_d = 1'b1;
              if_data_d = w_rd_data;
              state_d   = ST_RESP;
            end else begin
              pc_d    = fetch_if.pc;
              w_inv   = 1'b1;
              cnt_d   = '0;
              mc_en_d = 1'b1;
              mc_pc_d = fetch_if.pc & ~LINE_MASK;
              state_d = ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          if (mem_if.done) begin
            w_data_we = 1'b1;
            if (cnt_q == w_rf_word) capt_d = mem_if.data;
            if (cnt_q == LAST) begin
              w_tag_we  = 1'b1;
              mc_en_d   = 1'b0;
              if_done_d = 1'b1;
              if_data_d = (w_rf_word == LAST) ? mem_if.data : capt_q;
              state_d   = ST_RESP;
            end else begin
              cnt_d   = cnt_q + WORD_W'(1);
              mc_pc_d = mc_pc_q + ADDR_WID'(4);
            end
          end
        end
        ST_RESP: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mc_en_q   <= 1'b0;
      mc_pc_q   <= '0;
      if_done_q <= 1'b0;
      if_data_q <= '0;
      pc_q      <= '0;
      capt_q    <= '0;
    end else if (rdy_i) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mc_en_q   <= mc_en_d;
      mc_pc_q   <= mc_pc_d;
      if_done_q <= if_done_d;
      if_data_q <= if_data_d;
      pc_q      <= pc_d;
      capt_q    <= capt_d;
    end
  end

  assign fetch_if.done = if_done_q;
  assign fetch_if.data = if_data_q;
  assign mem_if.en     = mc_en_q;
  assign mem_if.pc     = mc_pc_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_q, perf_miss_q;
  logic        w_lookup;

  assign w_lookup = (state_q == ST_IDLE) && fetch_if.en && !rollback_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else if (rdy_i && w_lookup) begin
      if (w_hit) perf_hit_q  <= perf_hit_q + 32'd1;
      else       perf_miss_q <= perf_miss_q + 32'd1;
    end
  end

  assign perf_hit_o  = perf_hit_q;
  assign perf_miss_o = perf_miss_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_icache_ctrl: directed + random fetches against a line-presence model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_icache_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic rollback = 1'b0;

  icache_ctrl_if fetch_bus ();
  icache_ctrl_if mem_bus ();

`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit, perf_miss;
`endif

  icache_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy_i      (rdy),
    .rollback_i (rollback),
    .fetch_if   (fetch_bus),
    .mem_if     (mem_bus)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hit_o (perf_hit),
    .perf_miss_o(perf_miss)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mv[64];
  int mt[64];
  int n_hit = 0;
  int n_miss = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic clr_model();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    n_hit  = 0;
    n_miss = 0;
  endtask

  // mode: 0 plain, 1 rollback after 2nd word, 2 rollback with last word, 3 rdy stall on word 1
  task automatic fetch(input logic [31:0] pc, input int mode);
    int idx, tg, lat;
    bit hit;
    logic [31:0] base;
    idx  = int'((pc / 16) % 64);
    tg   = int'(pc / 1024);
    base = pc - (pc % 16);
    hit  = mv[idx] && (mt[idx] == tg);
    fetch_bus.en = 1'b1;
    fetch_bus.pc = pc;
    @(posedge clk); #1;
    if (hit) begin
      n_hit++;
      chk("hit_done", 32'(fetch_bus.done), 32'd1);
      chk("hit_data", fetch_bus.data, memw(pc));
      chk("hit_no_mc", 32'(mem_bus.en), 32'd0);
      fetch_bus.en = 1'b0;
      @(posedge clk); #1;
      chk("hit_pulse_end", 32'(fetch_bus.done), 32'd0);
      return;
    end
    n_miss++;
    mv[idx] = 1'b0;
    chk("miss_mc_en", 32'(mem_bus.en), 32'd1);
    chk("miss_no_done", 32'(fetch_bus.done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      lat = int'($urandom_range(0, 2));
      for (int w = 0; w < lat; w++) begin @(posedge clk); #1; end
      chk("refill_pc", mem_bus.pc, base + 32'(4 * k));
      chk("refill_en", 32'(mem_bus.en), 32'd1);
      if (mode == 3 && k == 1) begin
        rdy = 1'b0;
        mem_bus.done = 1'b1;
        mem_bus.data = memw(base + 32'(4 * k));
        for (int s = 0; s < 3; s++) begin
          @(posedge clk); #1;
          chk("stall_pc", mem_bus.pc, base + 32'd4);
          chk("stall_en", 32'(mem_bus.en), 32'd1);
          chk("stall_done", 32'(fetch_bus.done), 32'd0);
        end
        rdy = 1'b1;
      end
      mem_bus.done = 1'b1;
      mem_bus.data = memw(base + 32'(4 * k));
      if (mode == 2 && k == 3) begin
        rollback = 1'b1;
        fetch_bus.en = 1'b0;
      end
      @(posedge clk); #1;
      mem_bus.done = 1'b0;
      if (mode == 2 && k == 3) begin
        rollback = 1'b0;
        chk("rb_last_en", 32'(mem_bus.en), 32'd0);
        chk("rb_last_done", 32'(fetch_bus.done), 32'd0);
        @(posedge clk); #1;
        chk("rb_last_done2", 32'(fetch_bus.done), 32'd0);
        return;
      end
      if (mode == 1 && k == 1) begin
        rollback = 1'b1;
        fetch_bus.en = 1'b0;
        @(posedge clk); #1;
        rollback = 1'b0;
        chk("rb_mid_en", 32'(mem_bus.en), 32'd0);
        chk("rb_mid_done", 32'(fetch_bus.done), 32'd0);
        @(posedge clk); #1;
        chk("rb_mid_done2", 32'(fetch_bus.done), 32'd0);
        return;
      end
    end
    chk("refill_done", 32'(fetch_bus.done), 32'd1);
    chk("refill_data", fetch_bus.data, memw(pc));
    chk("refill_mc_off", 32'(mem_bus.en), 32'd0);
    fetch_bus.en = 1'b0;
    mv[idx] = 1'b1;
    mt[idx] = tg;
    @(posedge clk); #1;
    chk("refill_pulse_end", 32'(fetch_bus.done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fetch_bus.en = 1'b0;
    fetch_bus.pc = '0;
    mem_bus.done = 1'b0;
    mem_bus.data = '0;
    clr_model();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_done", 32'(fetch_bus.done), 32'd0);
    chk("rst_if_data", fetch_bus.data, 32'd0);
    chk("rst_mc_en", 32'(mem_bus.en), 32'd0);
    chk("rst_mc_pc", mem_bus.pc, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fetch(32'h0000_0008, 0);
    fetch(32'h0000_000C, 0);
`ifdef ICACHE_PERF_EN
    chk("perf_hit_1", perf_hit, 32'd1);
    chk("perf_miss_1", perf_miss, 32'd1);
`endif
    fetch(32'h0000_0400, 0);
    fetch(32'h0000_0000, 0);
    fetch(32'h0000_0020, 1);
    fetch(32'h0000_0020, 0);
    fetch(32'h0000_0044, 2);
    fetch(32'h0000_0044, 0);
    fetch(32'h0000_0088, 3);
    fetch(32'h0000_0084, 0);

    mem_bus.done = 1'b1;
    mem_bus.data = $urandom;
    @(posedge clk); #1;
    mem_bus.done = 1'b0;
    chk("idle_done_ignored_en", 32'(mem_bus.en), 32'd0);
    chk("idle_done_ignored_done", 32'(fetch_bus.done), 32'd0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] rpc;
      int rmode;
      rpc   = 32'($urandom_range(0, 2)) * 32'd1024 + 32'($urandom_range(0, 3)) * 32'd16
              + 32'($urandom_range(0, 3)) * 32'd4;
      rmode = int'($urandom_range(0, 9));
      fetch(rpc, (rmode < 7) ? 0 : rmode - 6);
    end
`ifdef ICACHE_PERF_EN
    chk("perf_hit_rand", perf_hit, 32'(n_hit));
    chk("perf_miss_rand", perf_miss, 32'(n_miss));
`endif

    fetch_bus.en = 1'b1;
    fetch_bus.pc = 32'h0000_0104;
    @(posedge clk); #1;
    chk("pre_rst_mc_en", 32'(mem_bus.en), 32'd1);
    mem_bus.done = 1'b1;
    mem_bus.data = memw(32'h0000_0100);
    @(posedge clk); #1;
    mem_bus.done = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mc_en", 32'(mem_bus.en), 32'd0);
    chk("async_rst_mc_pc", mem_bus.pc, 32'd0);
    chk("async_rst_done", 32'(fetch_bus.done), 32'd0);
    fetch_bus.en = 1'b0;
    clr_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fetch(32'h0000_000C, 0);
    fetch(32'h0000_000C, 0);
`ifdef ICACHE_PERF_EN
    chk("perf_hit_post_rst", perf_hit, 32'd1);
    chk("perf_miss_post_rst", perf_miss, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
Direct-mapped instruction cache and refill sequencer between IFetch and MemCtrl. Serves IFetch word fetches from a local line array. On a miss it sequences word-by-word line refills through MemCtrl's 32-bit instruction port. It aborts cleanly on ROB rollback.

Parameters:
OFFSET_BITS, 4, log2 line size in bytes (16 B line = 4 words); minimum 2
INDEX_BITS, 6, log2 number of lines (64 lines)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
rdy  in  1  global ready; when low, all state frozen
rollback  in  1  ROB mispredict flush
if_en  in  1  IFetch request; held high until if_done
if_pc  in  32  fetch address, word aligned
if_done  out  1  one-cycle pulse: if_data valid
if_data  out  32  fetched instruction
mc_en  out  1  word request to MemCtrl; held until mc_done
mc_pc  out  32  word address of request
mc_done  in  1  one-cycle pulse: mc_data valid
mc_data  in  32  returned word

Behaviour:
- Address split: tag = pc[31:OFFSET_BITS+INDEX_BITS], index = pc[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS], word = pc[OFFSET_BITS-1:2]. Bits [1:0] are ignored.
- Arrays: valid[2^INDEX_BITS], tag[2^INDEX_BITS], data[2^INDEX_BITS][2^(OFFSET_BITS-2)] x 32.
- Reset (rst=0, async): state=IDLE, all valid=0, if_done=0, if_data=0, mc_en=0, mc_pc=0, counters=0. The tag and data arrays are not reset.
- rdy=0: no state, array, or output change. Pulses stay asserted until rdy returns.
- States: IDLE, REFILL, RESP.
- IDLE:
  - Samples if_en.
  - Hit (valid && tag match): next cycle if_done=1 and if_data=line word; go to RESP. Hit latency is 1 cycle.
  - Miss: latch pc, clear valid[index], set word counter cnt=0, mc_en=1, mc_pc={pc[31:OFFSET_BITS], 0...}; go to REFILL.
- REFILL:
  - On mc_done, write mc_data into data[index][cnt] and capture the word if cnt equals the requested word.
  - If cnt < last: cnt+1, mc_pc+=4, keep mc_en=1. mc_en stays high between words; MemCtrl treats a changed mc_pc as a new request.
  - On the last word: write tag, set valid=1, mc_en=0, if_done=1, if_data=requested word; go to RESP. Refill latency is 2^(OFFSET_BITS-2) MemCtrl transactions plus 1 cycle.
- RESP: if_done high exactly this one cycle. if_en is ignored this cycle. Return to IDLE. Peak hit throughput is 1 per 2 cycles.
- rollback (priority over everything, including mc_done in the same cycle):
  - Next cycle: mc_en=0, if_done=0, state=IDLE.
  - A partially refilled line stays invalid. A last-word mc_done coinciding with rollback is discarded and the line is not installed.
  - if_en is not sampled in the rollback cycle.
- mc_done arriving outside REFILL is ignored.
- A request whose index equals the line currently refilling cannot occur, because IFetch issues one request at a time.

Optional Feature:
ICACHE_PERF_EN
- When defined: adds outputs perf_hit[31:0] and perf_miss[31:0].
  - Incremented on each IDLE lookup hit or miss.
  - Wrap at 2^32; reset to 0; frozen when rdy=0; not cleared by rollback.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared macros header:
  - ADDR_WID and INST_WID widths.
  - ICACHE_OFFSET_BITS and ICACHE_INDEX_BITS defaults.
  - State encodings ST_IDLE=2'd0, ST_REFILL=2'd1, ST_RESP=2'd2.
- One sub-module: icache_array (valid/tag/data storage with combinational read and synchronous write port, async-reset valid bits). The controller FSM stays in icache_ctrl.

Test Plan:
- Cold miss at if_pc=0x00000008 -> mc_pc sequence 0x0, 0x4, 0x8, 0xC, one per mc_done. if_done pulses one cycle after the 4th mc_done with if_data = the word returned for 0x8.
- After that refill, if_pc=0x0000000C -> no mc_en; if_done one cycle after if_en with the 0xC word; perf_hit=1, perf_miss=1.
- Conflict: if_pc=0x00000400 (index 0, new tag) -> full refill 0x400–0x40C. A subsequent if_pc=0x0 misses again.
- Rollback asserted the cycle after the 2nd mc_done of a refill at 0x20 -> mc_en=0 next cycle, no if_done. A later if_pc=0x20 refetches all 4 words.
- Rollback coincident with the last mc_done -> line not valid, no if_done. The next request to the same address misses.
- rdy=0 for 3 cycles mid-refill with mc_done asserted -> mc_pc, cnt, and outputs unchanged; progress resumes when rdy=1. Async rst=0 mid-refill -> mc_en=0 immediately and all lines invalid.
